// File: rtl/phy_types_pkg.sv
// Shared types for the 8b/10b PHY blocks.
package phy_types_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_t;

endpackage

// File: rtl/arb_counter_bank_if.sv
// Bundles the counter bank's signals for connection by the arbiters and credit logic.
interface arb_counter_bank_if
    import phy_types_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int NBITS   = 4,
    parameter int RST_VAL = 0
);
    logic                       CLK;
    logic                       RST;
    cnt_mode_t                  sat;
    logic [NCH-1:0]             en;
    logic [NCH-1:0]             dec;
    logic [NCH-1:0]             clear;
    logic [NCH-1:0]             load;
    logic [NCH-1:0][NBITS-1:0]  load_val;
    logic [NBITS-1:0]           threshold;
    logic [NCH-1:0][NBITS-1:0]  count;
    logic [NCH-1:0]             overflow;
    logic [NCH-1:0]             underflow;
    logic [NCH-1:0]             at_thresh;
    logic                       any_ovf;

    modport cnt (
        input  CLK, RST, sat, en, dec, clear, load, load_val, threshold,
        output count, overflow, underflow, at_thresh, any_ovf
    );
endinterface

// File: rtl/arb_counter_cell.sv
// One counter channel: count and sticky flags with clear > load > en/dec priority.
module arb_counter_cell
    import phy_types_pkg::*;
#(
    parameter int               NBITS   = 4,
    parameter logic [NBITS-1:0] RST_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  cnt_mode_t         sat,
    input  logic              en,
    input  logic              dec,
    input  logic              clear,
    input  logic              load,
    input  logic [NBITS-1:0]  load_val,
    output logic [NBITS-1:0]  count,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [NBITS-1:0] MAX_CNT = '1;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            count     <= RST_VAL;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (load) begin
            count     <= load_val;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (en && !dec) begin
            // At the top the flag fires; the count wraps or holds by mode.
            if (count == MAX_CNT) begin
                overflow <= 1'b1;
                if (sat == CNT_WRAP)
                    count <= '0;
            end else begin
                count <= count + NBITS'(1);
            end
        end else if (dec && !en) begin
            if (count == '0) begin
                underflow <= 1'b1;
                if (sat == CNT_WRAP)
                    count <= MAX_CNT;
            end else begin
                count <= count - NBITS'(1);
            end
        end
    end
endmodule

// File: rtl/arb_counter_bank.sv
// Bank of independent up/down counters with shared threshold compare.
module arb_counter_bank
    import phy_types_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int NBITS   = 4,
    parameter int RST_VAL = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  cnt_mode_t                  sat,
    input  logic [NCH-1:0]             en,
    input  logic [NCH-1:0]             dec,
    input  logic [NCH-1:0]             clear,
    input  logic [NCH-1:0]             load,
    input  logic [NCH-1:0][NBITS-1:0]  load_val,
    input  logic [NBITS-1:0]           threshold,
    output logic [NCH-1:0][NBITS-1:0]  count,
    output logic [NCH-1:0]             overflow,
    output logic [NCH-1:0]             underflow,
    output logic [NCH-1:0]             at_thresh,
    output logic                       any_ovf
);
    localparam logic [NBITS-1:0] RST_CNT = NBITS'(RST_VAL);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        arb_counter_cell #(
            .NBITS   (NBITS),
            .RST_VAL (RST_CNT)
        ) u_cell (
            .CLK       (CLK),
            .RST       (RST),
            .sat       (sat),
            .en        (en[i]),
            .dec       (dec[i]),
            .clear     (clear[i]),
            .load      (load[i]),
            .load_val  (load_val[i]),
            .count     (count[i]),
            .overflow  (overflow[i]),
            .underflow (underflow[i])
        );

        assign at_thresh[i] = (count[i] >= threshold);
    end

    assign any_ovf = |overflow;
endmodule
